// File: rtl/sd_cmd_serial_device.sv
// rtl/sd_cmd_serial_device.sv - SD CMD line device end: command receive/check and response transmit
// Optional macro SD_DEV_RSP_TIMEOUT_EN enables the WAIT_RSP timeout.
module sd_cmd_serial_device #(
    parameter int NCR        = 2,
    parameter int INIT_DELAY = 64
) (
    input  logic         SD_CLK_IN,
    input  logic         RST_IN,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic         CMD_VALID_OUT,
    output logic         CMD_ERR_OUT,
    output logic [5:0]   CMD_IDX_OUT,
    output logic [31:0]  CMD_ARG_OUT,
    input  logic         RSP_REQ_IN,
    input  logic         RSP_SKIP_IN,
    input  logic         RSP_LONG_IN,
    input  logic         RSP_NOCRC_IN,
    input  logic [5:0]   RSP_IDX_IN,
    input  logic [31:0]  RSP_ARG_IN,
    input  logic [127:0] RSP_DATA_IN,
    output logic         RSP_ACK_OUT,
    output logic         BUSY_OUT,
    output logic         RSP_TIMEOUT_OUT
);
    localparam int INIT_W = $clog2(INIT_DELAY + 1);
    localparam int CNT_W  = (INIT_W > 8) ? INIT_W : 8;

    typedef enum logic [2:0] {INIT, IDLE, RX_CMD, CHECK, WAIT_RSP, TX, DONE} state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [6:0]   crc_q, crc_d;
    logic [45:0]  sr_q, sr_d;
    logic [135:0] tx_q, tx_d;
    logic         long_q, long_d, nocrc_q, nocrc_d;
    logic         valid_q, valid_d, err_q, err_d, busy_q, busy_d, tmo_q, tmo_d;
    logic [5:0]   idx_q, idx_d;
    logic [31:0]  arg_q, arg_d;
    logic [46:0]  rx_vec;
    logic         good, tx_bit, tx_crc_phase;
    logic         unused_data0;

    assign unused_data0 = RSP_DATA_IN[0];

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= INIT;
            cnt_q   <= '0;
            crc_q   <= '0;
            sr_q    <= '0;
            tx_q    <= '0;
            long_q  <= 1'b0;
            nocrc_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            idx_q   <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            sr_q    <= sr_d;
            tx_q    <= tx_d;
            long_q  <= long_d;
            nocrc_q <= nocrc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
        end
    end

    // rx_vec holds bits 2..48 once the end bit is on the line
    always_comb begin
        cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        rx_vec       = {sr_q, cmd_dat_i};
        good         = rx_vec[46] && rx_vec[0] && (rx_vec[7:1] == crc_q);
        tx_crc_phase = !long_q && (cnt_q >= CNT_W'(40)) && (cnt_q < CNT_W'(47));
        tx_bit       = tx_crc_phase ? (nocrc_q | crc_q[6]) : tx_q[135];

        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        sr_d    = sr_q;
        tx_d    = tx_q;
        long_d  = long_q;
        nocrc_d = nocrc_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            INIT: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_W'(INIT_DELAY - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                crc_d = '0;
                if (!cmd_dat_i) begin
                    state_d = RX_CMD;
                    cnt_d   = CNT_W'(1);
                end
            end
            RX_CMD: begin
                sr_d  = rx_vec[45:0];
                cnt_d = cnt_inc;
                if (cnt_q < CNT_W'(40)) crc_d = crc7_step(crc_q, cmd_dat_i);
                if (cnt_q == CNT_W'(47)) begin
                    state_d = CHECK;
                    cnt_d   = CNT_W'(1);
                    if (good) begin
                        valid_d = 1'b1;
                        idx_d   = rx_vec[45:40];
                        arg_d   = rx_vec[39:8];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                cnt_d   = cnt_inc;
                state_d = valid_q ? WAIT_RSP : IDLE;
            end
            WAIT_RSP: begin
                cnt_d = cnt_inc;
                if (RSP_SKIP_IN) begin
                    state_d = IDLE;
                end else if (RSP_REQ_IN && (cnt_q >= CNT_W'(NCR))) begin
                    state_d = TX;
                    cnt_d   = '0;
                    crc_d   = '0;
                    long_d  = RSP_LONG_IN;
                    nocrc_d = RSP_NOCRC_IN;
                    tx_d    = RSP_LONG_IN ? {2'b00, 6'h3F, RSP_DATA_IN[127:1], 1'b1}
                                          : {2'b00, RSP_IDX_IN, RSP_ARG_IN, 7'h00, 1'b1, 88'h0};
                end
`ifdef SD_DEV_RSP_TIMEOUT_EN
                else if (!RSP_REQ_IN && (cnt_q == CNT_W'(65))) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
`endif
            end
            TX: begin
                tx_d  = {tx_q[134:0], 1'b0};
                cnt_d = cnt_inc;
                if (cnt_q < CNT_W'(40)) crc_d = crc7_step(crc_q, tx_bit);
                else if (tx_crc_phase) crc_d = {crc_q[5:0], 1'b0};
                if (cnt_q == (long_q ? CNT_W'(135) : CNT_W'(47))) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign cmd_oe_o        = (state_q == TX);
    assign cmd_out_o       = (state_q == TX) ? tx_bit : 1'b1;
    assign RSP_ACK_OUT     = (state_q == DONE);
    assign CMD_VALID_OUT   = valid_q;
    assign CMD_ERR_OUT     = err_q;
    assign CMD_IDX_OUT     = idx_q;
    assign CMD_ARG_OUT     = arg_q;
    assign BUSY_OUT        = busy_q;
    assign RSP_TIMEOUT_OUT = tmo_q;
endmodule

// File: tb/tb_sd_cmd_serial_device.sv
// tb/tb_sd_cmd_serial_device.sv - directed scoreboard bench for sd_cmd_serial_device
module tb_sd_cmd_serial_device;
    localparam int NCR        = 2;
    localparam int INIT_DELAY = 64;

    logic         clk = 1'b0;
    logic         RST_IN;
    logic         cmd_dat_i;
    logic         cmd_out_o, cmd_oe_o;
    logic         CMD_VALID_OUT, CMD_ERR_OUT;
    logic [5:0]   CMD_IDX_OUT;
    logic [31:0]  CMD_ARG_OUT;
    logic         RSP_REQ_IN, RSP_SKIP_IN, RSP_LONG_IN, RSP_NOCRC_IN;
    logic [5:0]   RSP_IDX_IN;
    logic [31:0]  RSP_ARG_IN;
    logic [127:0] RSP_DATA_IN;
    logic         RSP_ACK_OUT, BUSY_OUT, RSP_TIMEOUT_OUT;

    sd_cmd_serial_device #(.NCR(NCR), .INIT_DELAY(INIT_DELAY)) dut (
        .SD_CLK_IN(clk), .RST_IN(RST_IN), .cmd_dat_i(cmd_dat_i),
        .cmd_out_o(cmd_out_o), .cmd_oe_o(cmd_oe_o),
        .CMD_VALID_OUT(CMD_VALID_OUT), .CMD_ERR_OUT(CMD_ERR_OUT),
        .CMD_IDX_OUT(CMD_IDX_OUT), .CMD_ARG_OUT(CMD_ARG_OUT),
        .RSP_REQ_IN(RSP_REQ_IN), .RSP_SKIP_IN(RSP_SKIP_IN), .RSP_LONG_IN(RSP_LONG_IN),
        .RSP_NOCRC_IN(RSP_NOCRC_IN), .RSP_IDX_IN(RSP_IDX_IN), .RSP_ARG_IN(RSP_ARG_IN),
        .RSP_DATA_IN(RSP_DATA_IN), .RSP_ACK_OUT(RSP_ACK_OUT), .BUSY_OUT(BUSY_OUT),
        .RSP_TIMEOUT_OUT(RSP_TIMEOUT_OUT)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           len;
        logic [135:0] bits;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [37:0] cmd_q[$];
    int errors = 0, checks = 0;
    int n_valid = 0, n_err = 0, n_ack = 0, n_oe = 0;
    int exp_valid = 0, exp_err = 0, exp_ack = 0, exp_oe = 0;

    always @(negedge clk) begin
        if (CMD_VALID_OUT) n_valid++;
        if (CMD_ERR_OUT)   n_err++;
        if (RSP_ACK_OUT)   n_ack++;
        if (cmd_oe_o)      n_oe++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] build_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    // Drives a 48-bit frame; returns at the negedge of the cycle after the end bit
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cmd_dat_i = f[i];
        end
        @(negedge clk);
        cmd_dat_i = 1'b1;
    endtask

    task automatic expect_cmd();
        logic [37:0] e;
        e = cmd_q.pop_front();
        exp_valid++;
        chk("cmd_valid", CMD_VALID_OUT, 1'b1);
        chk("cmd_err", CMD_ERR_OUT, 1'b0);
        chk("cmd_idx", CMD_IDX_OUT, e[37:32]);
        chk("cmd_arg", CMD_ARG_OUT, e[31:0]);
    endtask

    task automatic send_good(input logic [5:0] idx, input logic [31:0] arg);
        cmd_q.push_back({idx, arg});
        send_frame(build_cmd(idx, arg));
        expect_cmd();
    endtask

    task automatic send_bad(input logic [47:0] f, input string tag);
        logic [5:0]  idx0;
        logic [31:0] arg0;
        idx0 = CMD_IDX_OUT;
        arg0 = CMD_ARG_OUT;
        exp_err++;
        send_frame(f);
        chk({tag, "_err"}, CMD_ERR_OUT, 1'b1);
        chk({tag, "_valid"}, CMD_VALID_OUT, 1'b0);
        chk({tag, "_idx"}, CMD_IDX_OUT, idx0);
        chk({tag, "_arg"}, CMD_ARG_OUT, arg0);
        tick(1);
        chk({tag, "_idle"}, BUSY_OUT, 1'b0);
    endtask

    task automatic do_skip();
        RSP_SKIP_IN = 1'b1;
        tick(2);
        RSP_SKIP_IN = 1'b0;
        chk("skip_idle", BUSY_OUT, 1'b0);
    endtask

    task automatic push_short(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc);
        rsp_t r;
        r.len  = 48;
        r.bits = {88'h0, 2'b00, idx, arg, nocrc ? 7'h7F : crc7({2'b00, idx, arg}), 1'b1};
        rsp_q.push_back(r);
    endtask

    task automatic push_long(input logic [127:0] data);
        rsp_t r;
        r.len  = 136;
        r.bits = {2'b00, 6'h3F, data[127:1], 1'b1};
        rsp_q.push_back(r);
    endtask

    // Called at the post-end-bit negedge; scrambles RSP_* inputs mid-frame
    task automatic capture_rsp(output logic [135:0] got);
        rsp_t e;
        int   gap, drv;
        e   = rsp_q.pop_front();
        gap = 0;
        drv = 0;
        got = '0;
        while (!cmd_oe_o && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        chk("rsp_gap", gap, NCR);
        for (int i = 0; i < e.len; i++) begin
            got = {got[134:0], cmd_out_o};
            if (cmd_oe_o) drv++;
            if (i == 3) begin
                RSP_IDX_IN   = ~RSP_IDX_IN;
                RSP_ARG_IN   = ~RSP_ARG_IN;
                RSP_DATA_IN  = ~RSP_DATA_IN;
                RSP_NOCRC_IN = ~RSP_NOCRC_IN;
                RSP_LONG_IN  = ~RSP_LONG_IN;
            end
            @(negedge clk);
        end
        RSP_REQ_IN = 1'b0;
        exp_ack++;
        exp_oe += e.len;
        chk("rsp_drive_len", drv, e.len);
        chk("rsp_frame", got, e.bits);
        chk("rsp_ack", RSP_ACK_OUT, 1'b1);
        chk("rsp_oe_after", cmd_oe_o, 1'b0);
        chk("rsp_line_after", cmd_out_o, 1'b1);
    endtask

    initial begin
        logic [135:0] got;
        logic [47:0]  f;
        logic [31:0]  rarg;
        int           n, ack0;

        RST_IN = 1'b1; cmd_dat_i = 1'b1;
        RSP_REQ_IN = 1'b0; RSP_SKIP_IN = 1'b0; RSP_LONG_IN = 1'b0; RSP_NOCRC_IN = 1'b0;
        RSP_IDX_IN = '0; RSP_ARG_IN = '0; RSP_DATA_IN = '0;
        #12;
        chk("rst_cmd_out", cmd_out_o, 1'b1);
        chk("rst_oe", cmd_oe_o, 1'b0);
        chk("rst_valid", CMD_VALID_OUT, 1'b0);
        chk("rst_err", CMD_ERR_OUT, 1'b0);
        chk("rst_idx", CMD_IDX_OUT, 6'd0);
        chk("rst_arg", CMD_ARG_OUT, 32'd0);
        chk("rst_ack", RSP_ACK_OUT, 1'b0);
        chk("rst_busy", BUSY_OUT, 1'b0);
        chk("rst_tmo", RSP_TIMEOUT_OUT, 1'b0);
        @(negedge clk);
        RST_IN = 1'b0;

        // A frame during INIT must be ignored
        tick(3);
        send_frame(build_cmd(6'd17, 32'h1));
        tick(INIT_DELAY - 40);
        #1;
        chk("init_ignore_valid", n_valid, 0);
        chk("init_ignore_err", n_err, 0);
        chk("init_done_idle", BUSY_OUT, 1'b0);

        // CMD0 literal frame, skipped response
        cmd_q.push_back(38'h0);
        send_frame(48'h40_0000_0000_95);
        expect_cmd();
        do_skip();

        // CMD17 with short response, REQ raised immediately
        send_good(6'd17, 32'h0000_1000);
        RSP_IDX_IN = 6'd17; RSP_ARG_IN = 32'h0000_0900; RSP_LONG_IN = 1'b0; RSP_NOCRC_IN = 1'b0;
        push_short(6'd17, 32'h0000_0900, 1'b0);
        RSP_REQ_IN = 1'b1;
        capture_rsp(got);
        tick(1);
        chk("post_rsp_idle", BUSY_OUT, 1'b0);

        // Short response with fixed 7F CRC and random payload
        send_good(6'd55, 32'hDEAD_BEEF);
        rarg = $urandom;
        RSP_IDX_IN = 6'd55; RSP_ARG_IN = rarg; RSP_LONG_IN = 1'b0; RSP_NOCRC_IN = 1'b1;
        push_short(6'd55, rarg, 1'b1);
        RSP_REQ_IN = 1'b1;
        capture_rsp(got);
        tick(2);

        // Bad commands: CRC bit, end bit, transmission bit; IDX/ARG must hold
        send_good(6'd17, 32'h0000_1000);
        do_skip();
        f = build_cmd(6'd17, 32'h0000_1000);
        send_bad(f ^ 48'h8, "bad_crc");
        send_bad(f & ~48'h1, "bad_end");
        send_bad(f ^ (48'h1 << 46), "bad_trans");

        // Long response
        send_good(6'd2, 32'h0);
        RSP_DATA_IN = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A0123;
        RSP_LONG_IN = 1'b1; RSP_NOCRC_IN = 1'b0;
        push_long(128'hFEDCBA98_76543210_0F1E2D3C_4B5A0123);
        RSP_REQ_IN = 1'b1;
        capture_rsp(got);
        chk("long_ones", got[133:128], 6'h3F);
        chk("long_end", got[0], 1'b1);
        tick(2);

        // Reset at response bit 20
        send_good(6'd17, 32'h0000_1000);
        RSP_IDX_IN = 6'd17; RSP_ARG_IN = 32'h0000_0900; RSP_LONG_IN = 1'b0; RSP_NOCRC_IN = 1'b0;
        RSP_REQ_IN = 1'b1;
        n = 0;
        while (!cmd_oe_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("rstmid_gap", n, NCR);
        tick(19);
        exp_oe += 20;
        ack0 = n_ack;
        #2 RST_IN = 1'b1;
        #1;
        chk("rstmid_oe", cmd_oe_o, 1'b0);
        chk("rstmid_line", cmd_out_o, 1'b1);
        tick(3);
        RST_IN = 1'b0;
        RSP_REQ_IN = 1'b0;
        #1;
        chk("rstmid_no_ack", n_ack, ack0);
        chk("rstmid_idx_cleared", CMD_IDX_OUT, 6'd0);
        tick(INIT_DELAY + 4);
        cmd_q.push_back(38'h0);
        send_frame(48'h40_0000_0000_95);
        expect_cmd();
        do_skip();

        // No REQ/SKIP while waiting for response
        send_good(6'd9, 32'h1234_5678);
`ifdef SD_DEV_RSP_TIMEOUT_EN
        n = 0;
        while (!RSP_TIMEOUT_OUT && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycle", n, 65);
        chk("tmo_idle", BUSY_OUT, 1'b0);
        tick(1);
        chk("tmo_pulse_end", RSP_TIMEOUT_OUT, 1'b0);
`else
        tick(200);
        chk("notmo_busy", BUSY_OUT, 1'b1);
        chk("notmo_tmo", RSP_TIMEOUT_OUT, 1'b0);
        chk("notmo_undriven", cmd_oe_o, 1'b0);
        do_skip();
`endif

        tick(2);
        #1;
        chk("total_valid", n_valid, exp_valid);
        chk("total_err", n_err, exp_err);
        chk("total_ack", n_ack, exp_ack);
        chk("total_oe", n_oe, exp_oe);
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
